sram_arbiter_2p: RTL and testbench
==================================

// Module: sram_arbiter_2p
// PURPOSE
//  Shares one 32-bit SRAM controller (3-cycle read, 2-cycle write, one-cycle ack pulse) between
//  two requesters, e.g. port 0 = instruction fetch, port 1 = load/store unit.
//  Arbitrates, latches the winning request, issues exactly one 1-cycle command to the controller,
//  waits for its ack, and returns data/ack to the winner. A watchdog aborts hung transactions.
// PARAMETERS
//  RR_EN        1   1: round-robin on simultaneous requests; 0: fixed priority, port 0 wins
//  TIMEOUT_CYC  15  max WAIT cycles before abort with error (>=4); counter width $clog2(TIMEOUT_CYC+1)
// PORTS
//  i_clk          in   1   clock
//  i_reset        in   1   synchronous, active-low reset
//  i_pN_req       in   1   (N=0,1) request; held high, with fields stable, until o_pN_ack
//  i_pN_we        in   1   1 = write, 0 = read
//  i_pN_addr      in   19  byte address; word-aligned, bits [1:0] ignored
//  i_pN_wdata     in   32  write data
//  i_pN_bmask     in   4   byte enables, active high
//  o_pN_rdata     out  32  read data, valid only while o_pN_ack=1 and o_pN_err=0
//  o_pN_ack       out  1   one-cycle completion pulse
//  o_pN_err       out  1   qualifies o_pN_ack: 1 = timeout abort
//  o_mem_addr     out  18  controller halfword address = {addr[18:2],1'b0}
//  o_mem_wdata    out  32  controller write data
//  o_mem_bmask    out  4   controller byte mask
//  o_mem_wren     out  1   controller write strobe, one cycle per transaction
//  o_mem_rden     out  1   controller read strobe, one cycle per transaction
//  i_mem_rdata    in   32  controller read data
//  i_mem_ack      in   1   controller ack pulse
//  o_busy         out  1   1 when state != IDLE
//  o_grant        out  1   port currently or last granted
// BEHAVIOUR
//  States: IDLE, ISSUE, WAIT.
//  - IDLE: if any i_pN_req, choose a winner, latch we/addr/wdata/bmask, set grant, go to ISSUE.
//  - ISSUE: drive o_mem_wren=we or o_mem_rden=~we for exactly this cycle; clear timer; go to WAIT.
//  - WAIT: both strobes low; timer increments each cycle.
//    - On i_mem_ack: o_pG_ack=1 and o_pG_rdata=i_mem_rdata (combinational pass-through),
//      last_grant<=G, go to IDLE.
//    - Else, when timer reaches TIMEOUT_CYC-1: o_pG_ack=1, o_pG_err=1, rdata=0, go to IDLE.
//  - Strobes are never high in IDLE or WAIT, so the controller cannot re-trigger in its ack state.
//  - o_mem_addr/wdata/bmask are driven from the latched registers in all states.
//  Arbitration:
//  - Only one requester: it wins.
//  - Both request, RR_EN=1: the port != last_grant wins. RR_EN=0: port 0 wins.
//  Latency, request first high in cycle 0 while IDLE:
//  - ISSUE in cycle 1. Write ack in cycle 3; read ack in cycle 4.
//  - Next IDLE sample is the cycle after ack, so the requester drops req on seeing ack.
//  - Minimum spacing: 4 cycles per write, 5 cycles per read.
//  - The losing requester waits with req high. No request is dropped or duplicated.
//  - A stray i_mem_ack in IDLE or ISSUE is ignored.
//  Reset (i_reset=0 at posedge, including mid-transaction):
//  - state=IDLE, grant=0, last_grant=1 (port 0 wins first RR tie), timer=0, latched fields=0.
//  - All o_pN_ack/err=0, o_mem_wren/rden=0, o_busy=0.
//  - An in-flight transaction is abandoned without ack. The controller is reset by the same
//    i_reset.
// TESTING
//  - Single read: p0 read addr 0x00010 -> o_mem_rden pulse in cycle 1 with o_mem_addr=0x00008;
//    model returns 0xDEADBEEF -> o_p0_ack, rdata=0xDEADBEEF in cycle 4, err=0.
//  - Single write: p1 write 0x00020, wdata 0x12345678, bmask 4'b0011 -> o_mem_wren pulse with
//    addr 0x00010, bmask 0011 -> o_p1_ack in cycle 3.
//  - Tie, RR_EN=1: both req every cycle -> grants alternate 0,1,0,1; each ack goes only to its
//    port; no missed or double acks.
//  - Tie, RR_EN=0: both req continuously -> p0 always served; p1 served once p0 drops req.
//  - Timeout: model never acks -> o_pG_ack=1, o_pG_err=1 after TIMEOUT_CYC WAIT cycles; then
//    IDLE and next request served.
//  - Reset in WAIT, cycle 2 of a read -> next cycle o_busy=0 and no ack; a new request after
//    reset completes normally.

Source files
------------

// File: rtl/sram_arbiter_2p.sv
// Two-port arbiter in front of a single 32-bit SRAM controller: latches the winning request,
// issues one command strobe, then returns the controller ack/data or a watchdog timeout error.
module sram_arbiter_2p #(
  parameter bit          RR_EN       = 1'b1,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_p0_req,
  input  logic        i_p0_we,
  input  logic [18:0] i_p0_addr,
  input  logic [31:0] i_p0_wdata,
  input  logic [3:0]  i_p0_bmask,
  output logic [31:0] o_p0_rdata,
  output logic        o_p0_ack,
  output logic        o_p0_err,
  input  logic        i_p1_req,
  input  logic        i_p1_we,
  input  logic [18:0] i_p1_addr,
  input  logic [31:0] i_p1_wdata,
  input  logic [3:0]  i_p1_bmask,
  output logic [31:0] o_p1_rdata,
  output logic        o_p1_ack,
  output logic        o_p1_err,
  output logic [17:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_bmask,
  output logic        o_mem_wren,
  output logic        o_mem_rden,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ack,
  output logic        o_busy,
  output logic        o_grant
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              we_q, we_d;
  logic [16:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        bmask_q, bmask_d;

  logic win, timeout, done, abort;
  logic unused_addr;

  // Byte-offset bits are meaningless for word accesses.
  assign unused_addr = ^{i_p0_addr[1:0], i_p1_addr[1:0]};

  always_comb begin
    if (i_p0_req && i_p1_req) begin
      win = RR_EN ? ~last_q : 1'b0;
    end else begin
      win = i_p1_req;
    end
  end

  assign timeout = (timer_q == TimerW'(TIMEOUT_CYC - 1));
  assign done    = (state_q == StWait) && (i_mem_ack || timeout);
  assign abort   = (state_q == StWait) && !i_mem_ack && timeout;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= StIdle;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      timer_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      bmask_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      bmask_q <= bmask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (i_p0_req || i_p1_req) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    grant_d = grant_q;
    last_d  = last_q;
    timer_d = timer_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    bmask_d = bmask_q;
    case (state_q)
      StIdle: begin
        if (i_p0_req || i_p1_req) begin
          grant_d = win;
          we_d    = win ? i_p1_we : i_p0_we;
          addr_d  = win ? i_p1_addr[18:2] : i_p0_addr[18:2];
          wdata_d = win ? i_p1_wdata : i_p0_wdata;
          bmask_d = win ? i_p1_bmask : i_p0_bmask;
        end
      end
      StIssue: timer_d = '0;
      StWait: begin
        timer_d = timer_q + TimerW'(1);
        // Only a real completion moves the round-robin pointer.
        if (i_mem_ack) last_d = grant_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    o_mem_wren = (state_q == StIssue) && we_q;
    o_mem_rden = (state_q == StIssue) && !we_q;
    o_busy     = (state_q != StIdle);
    o_p0_ack   = done && !grant_q;
    o_p0_err   = abort && !grant_q;
    o_p1_ack   = done && grant_q;
    o_p1_err   = abort && grant_q;
    o_p0_rdata = (o_p0_ack && !abort) ? i_mem_rdata : '0;
    o_p1_rdata = (o_p1_ack && !abort) ? i_mem_rdata : '0;
  end

  assign o_mem_addr  = {addr_q, 1'b0};
  assign o_mem_wdata = wdata_q;
  assign o_mem_bmask = bmask_q;
  assign o_grant     = grant_q;

endmodule

// File: tb/tb_sram_arbiter_2p.sv
// Scoreboard bench for sram_arbiter_2p: a round-robin and a fixed-priority instance share stimulus;
// sel picks which one drives the controller model and the monitor.
module tb_sram_arbiter_2p;
  localparam int unsigned TO = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        p0_req, p0_we, p1_req, p1_we;
  logic [18:0] p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic [3:0]  p0_bmask, p1_bmask;
  logic [31:0] mem_rdata;
  logic        mem_ack, ack_r;
  bit          noack, stray;
  int          sel;

  logic [31:0] a_p0_rdata [2];
  logic [31:0] a_p1_rdata [2];
  logic [31:0] a_wdata    [2];
  logic [17:0] a_addr     [2];
  logic [3:0]  a_bmask    [2];
  logic [1:0]  a_p0_ack, a_p0_err, a_p1_ack, a_p1_err, a_wren, a_rden, a_busy, a_grant;

  sram_arbiter_2p #(.RR_EN(1'b1), .TIMEOUT_CYC(TO)) u_rr (
    .i_clk(clk), .i_reset(rst_n),
    .i_p0_req(p0_req), .i_p0_we(p0_we), .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata),
    .i_p0_bmask(p0_bmask), .o_p0_rdata(a_p0_rdata[0]), .o_p0_ack(a_p0_ack[0]),
    .o_p0_err(a_p0_err[0]),
    .i_p1_req(p1_req), .i_p1_we(p1_we), .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata),
    .i_p1_bmask(p1_bmask), .o_p1_rdata(a_p1_rdata[0]), .o_p1_ack(a_p1_ack[0]),
    .o_p1_err(a_p1_err[0]),
    .o_mem_addr(a_addr[0]), .o_mem_wdata(a_wdata[0]), .o_mem_bmask(a_bmask[0]),
    .o_mem_wren(a_wren[0]), .o_mem_rden(a_rden[0]), .i_mem_rdata(mem_rdata),
    .i_mem_ack(mem_ack), .o_busy(a_busy[0]), .o_grant(a_grant[0])
  );

  sram_arbiter_2p #(.RR_EN(1'b0), .TIMEOUT_CYC(TO)) u_fp (
    .i_clk(clk), .i_reset(rst_n),
    .i_p0_req(p0_req), .i_p0_we(p0_we), .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata),
    .i_p0_bmask(p0_bmask), .o_p0_rdata(a_p0_rdata[1]), .o_p0_ack(a_p0_ack[1]),
    .o_p0_err(a_p0_err[1]),
    .i_p1_req(p1_req), .i_p1_we(p1_we), .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata),
    .i_p1_bmask(p1_bmask), .o_p1_rdata(a_p1_rdata[1]), .o_p1_ack(a_p1_ack[1]),
    .o_p1_err(a_p1_err[1]),
    .o_mem_addr(a_addr[1]), .o_mem_wdata(a_wdata[1]), .o_mem_bmask(a_bmask[1]),
    .o_mem_wren(a_wren[1]), .o_mem_rden(a_rden[1]), .i_mem_rdata(mem_rdata),
    .i_mem_ack(mem_ack), .o_busy(a_busy[1]), .o_grant(a_grant[1])
  );

  logic        ack0, ack1, err0, err1, m_wren, m_rden, m_busy, m_grant;
  logic [31:0] rd0, rd1, m_wdata;
  logic [17:0] m_addr;
  logic [3:0]  m_bmask;
  assign ack0    = a_p0_ack[sel];
  assign ack1    = a_p1_ack[sel];
  assign err0    = a_p0_err[sel];
  assign err1    = a_p1_err[sel];
  assign rd0     = a_p0_rdata[sel];
  assign rd1     = a_p1_rdata[sel];
  assign m_wren  = a_wren[sel];
  assign m_rden  = a_rden[sel];
  assign m_busy  = a_busy[sel];
  assign m_grant = a_grant[sel];
  assign m_addr  = a_addr[sel];
  assign m_wdata = a_wdata[sel];
  assign m_bmask = a_bmask[sel];

  // Controller model: ack 3 cycles after a read strobe, 2 after a write strobe.
  logic [31:0] mem [256];
  logic [7:0]  m_idx;
  int          mcnt;
  assign mem_ack = ack_r | stray;

  always @(negedge clk) begin
    if (!rst_n) begin
      mcnt  <= 0;
      ack_r <= 1'b0;
    end else if (m_wren || m_rden) begin
      mcnt  <= m_wren ? 2 : 3;
      m_idx <= m_addr[8:1];
      ack_r <= 1'b0;
      if (m_wren) begin
        for (int b = 0; b < 4; b++) begin
          if (m_bmask[b]) mem[m_addr[8:1]][8*b +: 8] <= m_wdata[8*b +: 8];
        end
      end
    end else if (mcnt > 0) begin
      mcnt      <= mcnt - 1;
      ack_r     <= (mcnt == 1) && !noack;
      mem_rdata <= mem[m_idx];
    end else begin
      ack_r <= 1'b0;
    end
  end

  typedef struct {
    logic        port;
    logic        we;
    logic [17:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bmask;
  } cmd_t;
  typedef struct {
    logic        err;
    logic        chkd;
    logic [31:0] data;
    int          lat;
  } rsp_t;

  cmd_t cq[$];
  rsp_t rq0[$];
  rsp_t rq1[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   start0 = 0;
  int   start1 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_cmd(input logic p, input logic we, input logic [17:0] a,
                          input logic [31:0] wd, input logic [3:0] bm);
    cmd_t c;
    c.port = p; c.we = we; c.addr = a; c.wdata = wd; c.bmask = bm;
    cq.push_back(c);
  endtask

  task automatic push_rsp(input logic p, input logic e, input logic chkd, input logic [31:0] d,
                          input int lat);
    rsp_t r;
    r.err = e; r.chkd = chkd; r.data = d; r.lat = lat;
    if (p) rq1.push_back(r);
    else rq0.push_back(r);
  endtask

  task automatic check_rsp(input logic p, input logic e, input logic [31:0] rd);
    rsp_t r;
    if (p) r = rq1.pop_front();
    else r = rq0.pop_front();
    chk(p ? "p1_err" : "p0_err", e, r.err);
    if (r.chkd) chk(p ? "p1_rdata" : "p0_rdata", rd, r.data);
    if (r.lat >= 0) chk(p ? "p1_latency" : "p0_latency", cyc - (p ? start1 : start0), r.lat);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a strobe or an ack.
  always @(negedge clk) begin
    cmd_t c;
    #1;
    if (rst_n) begin
      if (m_wren || m_rden) begin
        chk("strobe_exclusive", m_wren & m_rden, 1'b0);
        if (cq.size() == 0) begin
          chk("unexpected_strobe", m_wren | m_rden, 1'b0);
        end else begin
          c = cq.pop_front();
          chk("cmd_we", m_wren, c.we);
          chk("cmd_grant", m_grant, c.port);
          chk("cmd_addr", m_addr, c.addr);
          chk("cmd_bmask", m_bmask, c.bmask);
          if (c.we) chk("cmd_wdata", m_wdata, c.wdata);
        end
      end
      if (ack0 && ack1) chk("dual_ack", ack0 & ack1, 1'b0);
      if (ack0) begin
        if (rq0.size() == 0) chk("p0_unexpected_ack", ack0, 1'b0);
        else check_rsp(1'b0, err0, rd0);
      end
      if (ack1) begin
        if (rq1.size() == 0) chk("p1_unexpected_ack", ack1, 1'b0);
        else check_rsp(1'b1, err1, rd1);
      end
    end
  end

  task automatic txn(input logic p, input logic we, input logic [18:0] a, input logic [31:0] wd,
                     input logic [3:0] bm);
    bit got = 1'b0;
    @(posedge clk);
    #1;
    if (p) begin
      p1_req = 1'b1; p1_we = we; p1_addr = a; p1_wdata = wd; p1_bmask = bm; start1 = cyc;
    end else begin
      p0_req = 1'b1; p0_we = we; p0_addr = a; p0_wdata = wd; p0_bmask = bm; start0 = cyc;
    end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (p ? ack1 : ack0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk(p ? "p1_ack_wait" : "p0_ack_wait", 1'b0, 1'b1);
    if (p) p1_req = 1'b0;
    else p0_req = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0; p0_req = 1'b0; p1_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    sel = 0; noack = 1'b0; stray = 1'b0;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0; p0_bmask = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0; p1_bmask = '0;
    mem[8'h04] <= 32'hDEADBEEF;
    mem[8'h08] <= 32'hAAAAAAAA;
    mem[8'h10] <= 32'h11111111;
    mem[8'h20] <= 32'h22222222;
    mem[8'h21] <= 32'h33333333;

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_busy", m_busy, 1'b0);
    chk("rst_grant", m_grant, 1'b0);
    chk("rst_strobes", {m_wren, m_rden}, 2'b00);
    chk("rst_acks", {ack0, ack1}, 2'b00);
    chk("rst_errs", {err0, err1}, 2'b00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single read and write, then read back the partially written word.
    push_cmd(1'b0, 1'b0, 18'h00008, 32'h0, 4'hF);
    push_rsp(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 4);
    txn(1'b0, 1'b0, 19'h00010, 32'h0, 4'hF);
    push_cmd(1'b1, 1'b1, 18'h00010, 32'h12345678, 4'b0011);
    push_rsp(1'b1, 1'b0, 1'b0, 32'h0, 3);
    txn(1'b1, 1'b1, 19'h00020, 32'h12345678, 4'b0011);
    push_cmd(1'b1, 1'b0, 18'h00010, 32'h0, 4'hF);
    push_rsp(1'b1, 1'b0, 1'b1, 32'hAAAA5678, 4);
    txn(1'b1, 1'b0, 19'h00020, 32'h0, 4'hF);

    // Stray controller ack while idle must be ignored.
    repeat (2) @(posedge clk);
    #1;
    stray = 1'b1;
    @(posedge clk);
    #1;
    stray = 1'b0;

    // Round-robin tie: grants 0,1,0,1.
    push_cmd(1'b0, 1'b0, 18'h00020, 32'h0, 4'hF);
    push_cmd(1'b1, 1'b0, 18'h00040, 32'h0, 4'hF);
    push_cmd(1'b0, 1'b1, 18'h00022, 32'h5A5A5A5A, 4'hF);
    push_cmd(1'b1, 1'b0, 18'h00042, 32'h0, 4'hF);
    push_rsp(1'b0, 1'b0, 1'b1, 32'h11111111, 4);
    push_rsp(1'b0, 1'b0, 1'b0, 32'h0, -1);
    push_rsp(1'b1, 1'b0, 1'b1, 32'h22222222, 9);
    push_rsp(1'b1, 1'b0, 1'b1, 32'h33333333, -1);
    fork
      begin
        txn(1'b0, 1'b0, 19'h00040, 32'h0, 4'hF);
        txn(1'b0, 1'b1, 19'h00044, 32'h5A5A5A5A, 4'hF);
      end
      begin
        txn(1'b1, 1'b0, 19'h00080, 32'h0, 4'hF);
        txn(1'b1, 1'b0, 19'h00084, 32'h0, 4'hF);
      end
    join

    // Fixed priority: p0 served three times before p1.
    do_reset();
    sel = 1;
    push_cmd(1'b0, 1'b1, 18'h00080, 32'hCAFEF00D, 4'hF);
    push_cmd(1'b0, 1'b0, 18'h00080, 32'h0, 4'hF);
    push_cmd(1'b0, 1'b0, 18'h00008, 32'h0, 4'hF);
    push_cmd(1'b1, 1'b0, 18'h00042, 32'h0, 4'hF);
    push_rsp(1'b0, 1'b0, 1'b0, 32'h0, 3);
    push_rsp(1'b0, 1'b0, 1'b1, 32'hCAFEF00D, 4);
    push_rsp(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 4);
    push_rsp(1'b1, 1'b0, 1'b1, 32'h33333333, 18);
    fork
      begin
        txn(1'b0, 1'b1, 19'h00100, 32'hCAFEF00D, 4'hF);
        txn(1'b0, 1'b0, 19'h00100, 32'h0, 4'hF);
        txn(1'b0, 1'b0, 19'h00010, 32'h0, 4'hF);
      end
      txn(1'b1, 1'b0, 19'h00084, 32'h0, 4'hF);
    join

    // Watchdog abort, then a normal request is served.
    noack = 1'b1;
    push_cmd(1'b0, 1'b0, 18'h00008, 32'h0, 4'hF);
    push_rsp(1'b0, 1'b1, 1'b1, 32'h0, 16);
    txn(1'b0, 1'b0, 19'h00010, 32'h0, 4'hF);
    noack = 1'b0;
    push_cmd(1'b1, 1'b1, 18'h00012, 32'h0BADF00D, 4'b1100);
    push_rsp(1'b1, 1'b0, 1'b0, 32'h0, 3);
    txn(1'b1, 1'b1, 19'h00024, 32'h0BADF00D, 4'b1100);

    // Reset during WAIT abandons the read without ack.
    push_cmd(1'b0, 1'b0, 18'h00008, 32'h0, 4'hF);
    @(posedge clk);
    #1;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 19'h00010; p0_bmask = 4'hF;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    p0_req = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_reset_busy", m_busy, 1'b0);
    chk("post_reset_ack", ack0, 1'b0);
    chk("post_reset_grant", m_grant, 1'b0);
    repeat (4) @(posedge clk);
    push_cmd(1'b0, 1'b0, 18'h00008, 32'h0, 4'hF);
    push_rsp(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 4);
    txn(1'b0, 1'b0, 19'h00010, 32'h0, 4'hF);

    repeat (5) @(posedge clk);
    chk("cmd_queue_drained", cq.size(), 0);
    chk("p0_queue_drained", rq0.size(), 0);
    chk("p1_queue_drained", rq1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
